// File: rtl/jf_game_pkg.sv
`default_nettype none
// ============================================================================
// jf_game_pkg : shared screen widths, FSM encoding and defaults for game logic
// Revision    : 1.0 - initial release
// ============================================================================
package jf_game_pkg;

    localparam int X_W            = 10;
    localparam int Y_W            = 9;
    localparam int SEL_W          = 3;
    localparam int LIVES_W        = 2;
    localparam int LIVES_INIT_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/slim_hit_ctrl_if.sv
`default_nettype none
// ============================================================================
// slim_hit_ctrl_if : frame, player, slime-table and status bundle
// Revision         : 1.0 - initial release
// ============================================================================
interface slim_hit_ctrl_if;
    import jf_game_pkg::*;

    logic                 frame_tick;
    logic [X_W-1:0]       x_blue;
    logic [Y_W-1:0]       y_blue;
    logic [SEL_W-1:0]     slim_sel;
    logic [X_W-1:0]       x_slim;
    logic [Y_W-1:0]       y_slim;
    logic                 slim_frozen;
    logic                 slim_valid;
    logic                 busy;
    logic                 hit;
    logic [SEL_W-1:0]     hit_idx;
    logic [LIVES_W-1:0]   lives;
    logic                 game_over;
    logic                 invuln;

    modport slave (
        input  frame_tick, x_blue, y_blue, x_slim, y_slim, slim_frozen, slim_valid,
        output slim_sel, busy, hit, hit_idx, lives, game_over, invuln
    );

    modport master (
        output frame_tick, x_blue, y_blue, x_slim, y_slim, slim_frozen, slim_valid,
        input  slim_sel, busy, hit, hit_idx, lives, game_over, invuln
    );

endinterface
`default_nettype wire

// File: rtl/slim_box_cmp.sv
`default_nettype none
// ============================================================================
// slim_box_cmp : combinational strict window test |xa-xb|<HIT_DX, |ya-yb|<HIT_DY
// Revision     : 1.0 - initial release
// ============================================================================
module slim_box_cmp
    import jf_game_pkg::*;
#(
    parameter int HIT_DX = 55,
    parameter int HIT_DY = 38
)(
    input  wire logic [X_W-1:0] i_xa,
    input  wire logic [Y_W-1:0] i_ya,
    input  wire logic [X_W-1:0] i_xb,
    input  wire logic [Y_W-1:0] i_yb,
    output logic                o_hit
);

    localparam logic [X_W:0] c_dx = (X_W+1)'(HIT_DX);
    localparam logic [Y_W:0] c_dy = (Y_W+1)'(HIT_DY);

    logic signed [X_W:0] w_dx;
    logic signed [Y_W:0] w_dy;
    logic        [X_W:0] w_adx;
    logic        [Y_W:0] w_ady;

    // One extra bit keeps the difference signed, so small coordinates never wrap.
    assign w_dx  = $signed({1'b0, i_xa}) - $signed({1'b0, i_xb});
    assign w_dy  = $signed({1'b0, i_ya}) - $signed({1'b0, i_yb});
    assign w_adx = w_dx[X_W] ? $unsigned(-w_dx) : $unsigned(w_dx);
    assign w_ady = w_dy[Y_W] ? $unsigned(-w_dy) : $unsigned(w_dy);
    assign o_hit = (w_adx < c_dx) && (w_ady < c_dy);

endmodule
`default_nettype wire

// File: rtl/slim_hit_ctrl.sv
`default_nettype none
// ============================================================================
// slim_hit_ctrl : per-frame player/slime collision scan, lives and cooldown
// Option        : SLIM_INVULN_EN enables the post-hit invulnerability counter
// Revision      : 1.0 - initial release
// ============================================================================
module slim_hit_ctrl
    import jf_game_pkg::*;
#(
    parameter int N_SLIM        = 4,
    parameter int HIT_DX        = 55,
    parameter int HIT_DY        = 38,
    parameter int INVULN_FRAMES = 60,
    parameter int LIVES_INIT    = LIVES_INIT_DEF
)(
    input wire logic      clk,
    input wire logic      rst_n,
    slim_hit_ctrl_if.slave bus
);

    localparam logic [SEL_W-1:0] c_last = SEL_W'(N_SLIM - 1);

    state_e               state_q, state_d;
    logic [X_W-1:0]       x_lat_q, x_lat_d;
    logic [Y_W-1:0]       y_lat_q, y_lat_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic                 any_hit_q, any_hit_d;
    logic [SEL_W-1:0]     first_idx_q, first_idx_d;
    logic                 hit_q, hit_d;
    logic [SEL_W-1:0]     hit_idx_q, hit_idx_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic                 game_over_q, game_over_d;
    logic                 w_box_hit, w_slot_hit, w_invuln, w_take_hit;

    slim_box_cmp #(
        .HIT_DX (HIT_DX),
        .HIT_DY (HIT_DY)
    ) u_box (
        .i_xa  (x_lat_q),
        .i_ya  (y_lat_q),
        .i_xb  (bus.x_slim),
        .i_yb  (bus.y_slim),
        .o_hit (w_box_hit)
    );

    assign w_slot_hit = w_box_hit & bus.slim_valid & ~bus.slim_frozen;
    assign w_take_hit = (state_q == ST_REPORT) & any_hit_q & ~w_invuln & ~game_over_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.frame_tick) state_d = ST_SCAN;
            ST_SCAN:   if (sel_q == c_last) state_d = ST_REPORT;
            ST_REPORT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        x_lat_d     = x_lat_q;
        y_lat_d     = y_lat_q;
        sel_d       = sel_q;
        any_hit_d   = any_hit_q;
        first_idx_d = first_idx_q;
        hit_idx_d   = hit_idx_q;
        lives_d     = lives_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.frame_tick) begin
                    x_lat_d   = bus.x_blue;
                    y_lat_d   = bus.y_blue;
                    any_hit_d = 1'b0;
                    sel_d     = '0;
                end
            end
            ST_SCAN: begin
                if (w_slot_hit && !any_hit_q) begin
                    any_hit_d   = 1'b1;
                    first_idx_d = sel_q;
                end
                sel_d = (sel_q == c_last) ? '0 : sel_q + 1'b1;
            end
            default: ;
        endcase
        if (w_take_hit) begin
            hit_idx_d = first_idx_q;
            lives_d   = (lives_q == '0) ? '0 : lives_q - 1'b1;
        end
        hit_d       = w_take_hit;
        game_over_d = game_over_q | (lives_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_lat_q     <= '0;
            y_lat_q     <= '0;
            sel_q       <= '0;
            any_hit_q   <= 1'b0;
            first_idx_q <= '0;
            hit_q       <= 1'b0;
            hit_idx_q   <= '0;
            lives_q     <= LIVES_W'(LIVES_INIT);
            game_over_q <= 1'b0;
        end else begin
            x_lat_q     <= x_lat_d;
            y_lat_q     <= y_lat_d;
            sel_q       <= sel_d;
            any_hit_q   <= any_hit_d;
            first_idx_q <= first_idx_d;
            hit_q       <= hit_d;
            hit_idx_q   <= hit_idx_d;
            lives_q     <= lives_d;
            game_over_q <= game_over_d;
        end
    end

`ifdef SLIM_INVULN_EN
    localparam int c_cool_w = $clog2(INVULN_FRAMES + 2);
    // One extra count absorbs the tail of the hit frame, leaving INVULN_FRAMES whole frames protected.
    localparam logic [c_cool_w-1:0] c_cool_load = c_cool_w'(INVULN_FRAMES + 1);

    logic [c_cool_w-1:0] cool_q, cool_d;

    always_comb begin
        cool_d = cool_q;
        if (bus.frame_tick && (cool_q != '0)) cool_d = cool_q - 1'b1;
        if (w_take_hit)                       cool_d = c_cool_load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cool_q <= '0;
        else        cool_q <= cool_d;
    end

    assign w_invuln = (cool_q != '0);
`else
    // No cooldown in this build; only a meaningless negative setting could raise invuln.
    assign w_invuln = (INVULN_FRAMES < 0);
`endif

    assign bus.slim_sel  = sel_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.hit       = hit_q;
    assign bus.hit_idx   = hit_idx_q;
    assign bus.lives     = lives_q;
    assign bus.game_over = game_over_q;
    assign bus.invuln    = w_invuln;

endmodule
`default_nettype wire

// File: tb/tb_slim_hit_ctrl.sv
`default_nettype none
// ============================================================================
// tb_slim_hit_ctrl : directed self-checking bench for slim_hit_ctrl
// Revision         : 1.0 - initial release
// ============================================================================
module tb_slim_hit_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    slim_hit_ctrl_if bus();

    slim_hit_ctrl #(
        .N_SLIM        (4),
        .HIT_DX        (55),
        .HIT_DY        (38),
        .INVULN_FRAMES (2),
        .LIVES_INIT    (3)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [9:0] tx   [8];
    logic [8:0] ty   [8];
    logic       tfrz [8];
    logic       tval [8];

    always_comb begin
        bus.x_slim      = tx[bus.slim_sel];
        bus.y_slim      = ty[bus.slim_sel];
        bus.slim_frozen = tfrz[bus.slim_sel];
        bus.slim_valid  = tval[bus.slim_sel];
    end

    localparam int c_lat = 6;

`ifdef SLIM_INVULN_EN
    localparam logic c_inv_en = 1'b1;
    int exp_hit_t   [10] = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 0};
    int exp_lives_t [10] = '{2, 2, 2, 1, 1, 1, 0, 0, 0, 0};
    int exp_go_t    [10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    int exp_inv_t   [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
`else
    localparam logic c_inv_en = 1'b0;
    int exp_hit_t   [10] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    int exp_lives_t [10] = '{2, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    int exp_go_t    [10] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    int exp_inv_t   [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif

    // Window cases: player, slot position, expected hit
    int bpx_t [8] = '{0,  0,  0,  0,  0,    0,   100, 100};
    int bpy_t [8] = '{0,  0,  0,  0,  0,    0,   100, 100};
    int bsx_t [8] = '{10, 55, 54, 0,  1020, 0,   46,  45};
    int bsy_t [8] = '{5,  0,  37, 38, 0,    500, 63,  100};
    int bex_t [8] = '{1,  0,  1,  0,  0,    0,   1,   0};

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_hits;
    int         first_cyc;
    logic [2:0] sel_log  [16];
    logic       busy_log [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_table();
        for (int i = 0; i < 8; i++) begin
            tx[i]   = '0;
            ty[i]   = '0;
            tfrz[i] = 1'b0;
            tval[i] = 1'b0;
        end
    endtask

    task automatic set_slot(input int i, input int x, input int y, input logic frz, input logic vld);
        tx[i]   = 10'(x);
        ty[i]   = 9'(y);
        tfrz[i] = frz;
        tval[i] = vld;
    endtask

    task automatic set_player(input int x, input int y);
        bus.x_blue = 10'(x);
        bus.y_blue = 9'(y);
    endtask

    task automatic do_reset();
        bus.frame_tick = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".slim_sel"},  32'(bus.slim_sel),  0);
        check({tag, ".busy"},      32'(bus.busy),      0);
        check({tag, ".hit"},       32'(bus.hit),       0);
        check({tag, ".hit_idx"},   32'(bus.hit_idx),   0);
        check({tag, ".lives"},     32'(bus.lives),     3);
        check({tag, ".game_over"}, 32'(bus.game_over), 0);
        check({tag, ".invuln"},    32'(bus.invuln),    0);
    endtask

    // Pulse frame_tick, then watch 12 cycles; extra_k>1 re-pulses at that cycle.
    task automatic run_frame(input int extra_k);
        @(negedge clk);
        bus.frame_tick = 1'b1;
        n_hits    = 0;
        first_cyc = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) bus.frame_tick = 1'b0;
            sel_log[k]  = bus.slim_sel;
            busy_log[k] = bus.busy;
            if (bus.hit) begin
                n_hits++;
                if (first_cyc < 0) first_cyc = k;
            end
            if (extra_k > 1 && k == extra_k)          bus.frame_tick = 1'b1;
            else if (extra_k > 1 && k == extra_k + 1) bus.frame_tick = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, expected completion before 1 ms");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        bus.frame_tick = 1'b0;
        set_player(0, 0);
        clear_table();
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic hit in slot 2, latency and scan sequencing
        set_slot(2, 140, 120, 1'b0, 1'b1);
        set_player(100, 100);
        run_frame(0);
        check("t1.hits",      32'(n_hits),        1);
        check("t1.latency",   32'(first_cyc),     c_lat);
        check("t1.hit_idx",   32'(bus.hit_idx),   2);
        check("t1.lives",     32'(bus.lives),     2);
        check("t1.invuln",    32'(bus.invuln),    32'(c_inv_en));
        check("t1.game_over", 32'(bus.game_over), 0);
        check("t1.sel1",      32'(sel_log[1]),    0);
        check("t1.sel2",      32'(sel_log[2]),    1);
        check("t1.sel4",      32'(sel_log[4]),    3);
        check("t1.sel_rep",   32'(sel_log[5]),    0);
        check("t1.busy_scan", 32'(busy_log[1]),   1);
        check("t1.busy_rep",  32'(busy_log[5]),   1);
        check("t1.busy_idle", 32'(busy_log[6]),   0);

        // No overlap: hit_idx holds its last value
        clear_table();
        run_frame(0);
        check("t1b.hits",    32'(n_hits),      0);
        check("t1b.hit_idx", 32'(bus.hit_idx), 2);
        check("t1b.lives",   32'(bus.lives),   2);

        // Frozen slime does not hit
        do_reset();
        clear_table();
        set_slot(2, 140, 120, 1'b1, 1'b1);
        run_frame(0);
        check("t2.hits",  32'(n_hits),    0);
        check("t2.lives", 32'(bus.lives), 3);

        // Two overlapping slots: single pulse, lowest index
        do_reset();
        clear_table();
        set_slot(1, 100, 100, 1'b0, 1'b1);
        set_slot(3, 120, 90, 1'b0, 1'b1);
        run_frame(0);
        check("t3.hits",    32'(n_hits),      1);
        check("t3.hit_idx", 32'(bus.hit_idx), 1);
        check("t3.lives",   32'(bus.lives),   2);

        // frame_tick during SCAN is ignored
        do_reset();
        clear_table();
        set_slot(0, 100, 100, 1'b0, 1'b1);
        run_frame(2);
        check("t4.hits",    32'(n_hits),      1);
        check("t4.latency", 32'(first_cyc),   c_lat);
        check("t4.busy",    32'(busy_log[7]), 0);
        check("t4.lives",   32'(bus.lives),   2);

        // frame_tick during REPORT: ignored for scanning, cooldown reload wins
        do_reset();
        run_frame(5);
        check("t5.hits",   32'(n_hits),      1);
        check("t5.busy",   32'(busy_log[7]), 0);
        check("t5.invuln", 32'(bus.invuln),  32'(c_inv_en));
        run_frame(0);
        check("t5.next_hits", 32'(n_hits), 32'(!c_inv_en));

        // Window boundaries and no wrap-around
        for (int c = 0; c < 8; c++) begin
            do_reset();
            clear_table();
            set_player(bpx_t[c], bpy_t[c]);
            set_slot(c % 4, bsx_t[c], bsy_t[c], 1'b0, 1'b1);
            run_frame(0);
            check($sformatf("win%0d.hits", c), 32'(n_hits), 32'(bex_t[c]));
            if (bex_t[c] == 1) check($sformatf("win%0d.hit_idx", c), 32'(bus.hit_idx), 32'(c % 4));
        end

        // Continuous overlap until game over
        do_reset();
        clear_table();
        set_player(300, 200);
        set_slot(0, 300, 200, 1'b0, 1'b1);
        for (int f = 0; f < 10; f++) begin
            run_frame(0);
            check($sformatf("go%0d.hits", f),      32'(n_hits),        32'(exp_hit_t[f]));
            check($sformatf("go%0d.lives", f),     32'(bus.lives),     32'(exp_lives_t[f]));
            check($sformatf("go%0d.game_over", f), 32'(bus.game_over), 32'(exp_go_t[f]));
            check($sformatf("go%0d.invuln", f),    32'(bus.invuln),    32'(exp_inv_t[f]));
        end

        // Reset during SCAN cycle 2 abandons the scan
        do_reset();
        clear_table();
        set_player(200, 100);
        set_slot(0, 200, 100, 1'b0, 1'b1);
        @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        repeat (2) @(negedge clk);
        check("t6.sel_before", 32'(bus.slim_sel), 2);
        rst_n = 1'b0;
        #1;
        check_reset_vals("t6");
        @(negedge clk);
        rst_n  = 1'b1;
        n_hits = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.hit || bus.busy) n_hits++;
        end
        check("t6.after", 32'(n_hits),    0);
        check("t6.lives", 32'(bus.lives), 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/slim_hit_ctrl.md
SLIM_HIT_CTRL -- requirements
Module: slim_hit_ctrl

Interface
REQ-001 SHALL have parameter N_SLIM, default 4: number of slime slots scanned per frame (2..8).
REQ-002 SHALL have parameter HIT_DX, default 55: horizontal hit half-window, pixels.
REQ-003 SHALL have parameter HIT_DY, default 38: vertical hit half-window, pixels.
REQ-004 SHALL have parameter INVULN_FRAMES, default 60: post-hit invulnerable frames.
REQ-005 SHALL have parameter LIVES_INIT, default 3: lives at reset.
REQ-006 clk  input  1  system clock; all logic on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 frame_tick  input  1  one-cycle pulse at frame start.
REQ-009 x_blue  input  10  player x; y_blue  input  9  player y.
REQ-010 slim_sel  output  3  slot index driven to the slime table.
REQ-011 x_slim  input  10, y_slim  input  9, slim_frozen  input  1, slim_valid  input  1  attributes of slot slim_sel, valid in the same cycle (combinational lookup).
REQ-012 busy  output  1  scan in progress.
REQ-013 hit  output  1  one-cycle pulse: life lost this frame.
REQ-014 hit_idx  output  3  lowest slot that hit; held until next hit.
REQ-015 lives  output  2  remaining lives; game_over  output  1  lives reached 0 (sticky); invuln  output  1  cooldown active.

Function
REQ-016 SHALL implement states IDLE, SCAN, REPORT.
REQ-017 IDLE: on frame_tick, SHALL latch x_blue/y_blue, clear the any-hit flag, set slim_sel=0, go to SCAN.
REQ-018 SCAN: each cycle SHALL test slot slim_sel, then increment; after slot N_SLIM-1, go to REPORT; SCAN lasts exactly N_SLIM cycles.
REQ-019 Slot hits when slim_valid=1, slim_frozen=0, |x_blue-x_slim|<HIT_DX and |y_blue-y_slim|<HIT_DY (strict).
REQ-020 Differences SHALL be computed sign-extended at 11/10 bits; no wrap-around when a coordinate is less than the window (x_slim=10 with x_blue=0 is a hit).
REQ-021 First hitting slot per scan SHALL be captured; later hits in the same scan do not change it.
REQ-022 REPORT (one cycle): if any-hit and invuln=0 and game_over=0, SHALL assert hit, update hit_idx, decrement lives, load cooldown; then IDLE.
REQ-023 hit asserts on the clock after REPORT is entered; total latency frame_tick->hit = N_SLIM+2 cycles.
REQ-024 frame_tick while busy SHALL be ignored (no queuing); busy=1 in SCAN and REPORT.
REQ-025 Cooldown counter SHALL decrement on each frame_tick while nonzero; invuln = (counter != 0).
REQ-026 frame_tick coinciding with REPORT: decrement applies before a reload in the same cycle; reload wins.
REQ-027 lives SHALL saturate at 0; game_over asserts the cycle lives becomes 0 and holds until reset; scanning continues, hit suppressed.
REQ-028 slim_sel SHALL read 0 outside SCAN.

Reset
REQ-029 rst_n low SHALL asynchronously force: state IDLE, slim_sel 0, busy 0, hit 0, hit_idx 0, lives LIVES_INIT, game_over 0, cooldown 0, invuln 0.
REQ-030 Reset mid-SCAN SHALL abandon the scan; no hit is reported afterwards for it.

Configuration
REQ-031 Macro SLIM_INVULN_EN defined: cooldown per REQ-025/026. Undefined: no counter, invuln tied 0, every hit frame costs a life.

Structure
REQ-032 Shared package jf_game_pkg SHALL hold the state enum, screen width constants (X_W=10, Y_W=9) and LIVES_INIT default.
REQ-033 Window compare SHALL be sub-module slim_box_cmp (combinational, HIT_DX/HIT_DY parameters), reusable by other collision blocks.

Verification
REQ-034 Player (100,100), slot 2 at (140,120) unfrozen valid, others invalid; frame_tick -> hit at cycle N_SLIM+2, hit_idx=2, lives 3->2, invuln=1.
REQ-035 Same geometry, slot 2 frozen -> no hit, lives stay 3.
REQ-036 Slots 1 and 3 both overlapping -> single hit pulse, hit_idx=1, lives decrement by 1.
REQ-037 Continuous overlap, SLIM_INVULN_EN defined, INVULN_FRAMES=2 -> hits on frames 0,3,6; lives 3,2,1,0; game_over=1 after third hit, no further hit.
REQ-038 Player (0,0), slot at (10,5) -> hit (no wrap); slot at (55,0) -> no hit (boundary exclusive).
REQ-039 rst_n low during SCAN cycle 2 -> all outputs at reset values, no hit pulse after release.
